bsg_link_sdr_sync_rx: RTL and testbench
=======================================

Name: bsg_link_sdr_sync_rx

Overview:
Single-clock receive endpoint for the SDR link, the far end of the link upstream transmitter. It is used where the link clock and the consuming logic share one clock, such as an FPGA bridge or a loopback test harness. It registers link_v_i/link_data_i, buffers words in a credit-sized FIFO, and presents them on a valid/yumi core interface. It returns credits to the transmitter as token pulses, one pulse per 2^lg_credit_to_token_decimation_p dequeued words.

Parameters:
width_p, 16, link/core data width in bits
lg_fifo_depth_p, 3, log2 of FIFO depth; the transmitter's initial credit count is 2^lg_fifo_depth_p
lg_credit_to_token_decimation_p, 1, log2 of words returned per token pulse; must be <= lg_fifo_depth_p

Ports:
core_clk_i  in  1  sole clock; also the link receive clock
core_reset_n_i  in  1  synchronous, active-low reset
link_v_i  in  1  link word valid
link_data_i  in  width_p  link word
link_token_o  out  1  registered credit token; each rising edge returns 2^lg_credit_to_token_decimation_p credits
core_v_o  out  1  FIFO head valid
core_data_o  out  width_p  FIFO head data
core_yumi_i  in  1  core consumes head this cycle; legal only when core_v_o=1
overflow_o  out  1  sticky: a word arrived while the FIFO was full

Behaviour:
- Reset (core_reset_n_i=0 sampled at posedge):
  - input valid register, FIFO pointers, credit counter, pending-token counter, link_token_o and overflow_o all clear to 0.
  - core_v_o=0 from the cycle after reset. Data registers need not reset.
  - Reset mid-traffic discards all buffered words and pending tokens. The transmitter must be reset with it.
- Input stage: v_r/data_r register link_v_i/link_data_i every cycle. data_r loads only when link_v_i=1.
- Enqueue: v_r=1 writes data_r at the tail on the next posedge.
  - Word on link at cycle n appears on core_v_o/core_data_o at cycle n+2 if the FIFO was empty. Total latency is 2 cycles.
- FIFO: 2^lg_fifo_depth_p entries; circular pointers of lg_fifo_depth_p bits plus one wrap bit.
  - full = pointers equal with wrap bits differing.
  - empty = pointers fully equal.
  - Wrap-around at the last entry returns to entry 0.
- Simultaneous enqueue and yumi:
  - When full: the dequeue frees a slot, so the enqueue is accepted and the FIFO stays full; no overflow.
  - When empty: no bypass. The new word appears the next cycle and yumi is illegal that cycle.
- Overflow: v_r=1 while full and no yumi drops the word and sets overflow_o=1. overflow_o stays set until reset. The FIFO contents are unchanged.
- Yumi with core_v_o=0 is illegal. The FIFO ignores it and no credit is counted. The bench flags it.
- Credit counter:
  - lg_credit_to_token_decimation_p bits; +1 per yumi.
  - When it wraps from all-ones to 0 (or on every yumi if decimation=0), pending_tokens increments.
- pending_tokens: lg_fifo_depth_p+1 bits; it never exceeds 2^(lg_fifo_depth_p-decimation).
- Token FSM (states LOW, HIGH; state equals link_token_o):
  - LOW -> HIGH when pending_tokens>0, with pending_tokens decremented.
  - HIGH -> LOW unconditionally.
  - Each pulse is therefore exactly 1 cycle high, with at least 1 cycle low between pulses. Maximum rate is one token per 2 cycles.
  - Increment and decrement of pending_tokens in the same cycle leave it unchanged.
- Token latency: the yumi that completes a token group at cycle n gives link_token_o=1 at cycle n+1 if the FSM is in LOW and no tokens are pending. Otherwise it is queued.
- Credit invariant: FIFO occupancy + v_r + uncounted credits + 2^decim*(pending_tokens + link_token_o) <= 2^lg_fifo_depth_p. This holds at all times for a compliant transmitter.

Test Plan:
- Reset: hold core_reset_n_i=0 for 3 cycles with link_v_i=1 -> core_v_o=0, link_token_o=0, overflow_o=0. No word enqueued.
- Latency: single word 0xA5A5 at cycle 10 with core_yumi_i=0 -> core_v_o=1, core_data_o=0xA5A5 at cycle 12. No token emitted.
- Fill/wrap: width 16, depth 8, decimation 1. Send 0..7 back-to-back, yumi all, repeat 3 times -> data in order across pointer wrap. 4 token pulses per round, each 1 cycle high and separated by at least 1 low cycle.
- Full + simultaneous: fill to 8, then send 0x0100 while yumi of the head in the same cycle -> accepted, occupancy stays 8, overflow_o=0.
- Overflow: fill to 8, send 0xDEAD with no yumi -> overflow_o=1 the following cycle and remains 1. Subsequent dequeues yield the original 8 words only.
- Token backlog: decimation 0, 4 yumis on consecutive cycles -> exactly 4 pulses at cycles n+1, n+3, n+5, n+7. Reset asserted after the 2nd pulse -> no further pulses.

Source files
------------

// File: rtl/bsg_link_sdr_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : bsg_link_sdr_sync_rx
// Purpose  : Single-clock SDR link receiver: input register, credit-sized
//            FIFO with valid/yumi drain, and decimated credit-token return.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_link_sdr_sync_rx #(
    parameter int width_p                         = 16,
    parameter int lg_fifo_depth_p                 = 3,
    parameter int lg_credit_to_token_decimation_p = 1
) (
    input  logic               core_clk_i,
    input  logic               core_reset_n_i,
    input  logic               link_v_i,
    input  logic [width_p-1:0] link_data_i,
    output logic               link_token_o,
    output logic               core_v_o,
    output logic [width_p-1:0] core_data_o,
    input  logic               core_yumi_i,
    output logic               overflow_o
);

    localparam int c_depth = 1 << lg_fifo_depth_p;
    localparam logic [lg_fifo_depth_p:0] c_ptr_one = 1;

    typedef enum logic [0:0] {
        TOKEN_LOW  = 1'b0,
        TOKEN_HIGH = 1'b1
    } token_state_e;

    logic                      r_v;
    logic [width_p-1:0]        r_data;
    logic [width_p-1:0]        r_mem [c_depth];
    logic [lg_fifo_depth_p:0]  r_wptr;
    logic [lg_fifo_depth_p:0]  r_rptr;
    logic [lg_fifo_depth_p:0]  r_pending;
    logic                      r_overflow;
    token_state_e              r_state;
    token_state_e              w_state_next;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_deq;
    logic                      w_enq;
    logic                      w_token_inc;
    logic                      w_token_dec;
    logic [lg_fifo_depth_p:0]  w_inc_ext;
    logic [lg_fifo_depth_p:0]  w_dec_ext;

    // Input stage: valid every cycle, data only when a word is present.
    always_ff @(posedge core_clk_i) begin
        if (!core_reset_n_i) begin
            r_v <= 1'b0;
        end else begin
            r_v <= link_v_i;
        end
    end

    always_ff @(posedge core_clk_i) begin
        if (link_v_i) begin
            r_data <= link_data_i;
        end
    end

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[lg_fifo_depth_p] != r_rptr[lg_fifo_depth_p]) &&
                     (r_wptr[lg_fifo_depth_p-1:0] == r_rptr[lg_fifo_depth_p-1:0]);

    // A dequeue while full frees the slot the incoming word takes.
    assign w_deq = core_yumi_i & ~w_empty;
    assign w_enq = r_v & (~w_full | w_deq);

    always_ff @(posedge core_clk_i) begin
        if (w_enq) begin
            r_mem[r_wptr[lg_fifo_depth_p-1:0]] <= r_data;
        end
    end

    always_ff @(posedge core_clk_i) begin
        if (!core_reset_n_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_deq) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            if (r_v && w_full && !w_deq) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign core_v_o    = ~w_empty;
    assign core_data_o = r_mem[r_rptr[lg_fifo_depth_p-1:0]];
    assign overflow_o  = r_overflow;

    generate
        if (lg_credit_to_token_decimation_p == 0) begin : g_no_decim
            assign w_token_inc = w_deq;
        end else begin : g_decim
            localparam logic [lg_credit_to_token_decimation_p-1:0] c_credit_one = 1;
            logic [lg_credit_to_token_decimation_p-1:0] r_credit;

            always_ff @(posedge core_clk_i) begin
                if (!core_reset_n_i) begin
                    r_credit <= '0;
                end else if (w_deq) begin
                    r_credit <= r_credit + c_credit_one;
                end
            end

            assign w_token_inc = w_deq & (&r_credit);
        end
    endgenerate

    // A freshly completed group may launch a token immediately without
    // passing through the pending counter first.
    always_comb begin
        w_state_next = r_state;
        w_token_dec  = 1'b0;
        case (r_state)
            TOKEN_LOW: begin
                if ((r_pending != '0) || w_token_inc) begin
                    w_state_next = TOKEN_HIGH;
                    w_token_dec  = 1'b1;
                end
            end
            TOKEN_HIGH: begin
                w_state_next = TOKEN_LOW;
            end
            default: begin
                w_state_next = TOKEN_LOW;
            end
        endcase
    end

    assign w_inc_ext = {{lg_fifo_depth_p{1'b0}}, w_token_inc};
    assign w_dec_ext = {{lg_fifo_depth_p{1'b0}}, w_token_dec};

    always_ff @(posedge core_clk_i) begin
        if (!core_reset_n_i) begin
            r_state   <= TOKEN_LOW;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= r_pending + w_inc_ext - w_dec_ext;
        end
    end

    assign link_token_o = (r_state == TOKEN_HIGH);

endmodule
`default_nettype wire

// File: tb/tb_bsg_link_sdr_sync_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_link_sdr_sync_rx
// Purpose  : Directed self-checking bench for bsg_link_sdr_sync_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_link_sdr_sync_rx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with decimation 1
    logic        rst_n, link_v, tok, cv, yumi, ovf;
    logic [15:0] link_data, cdata;
    // Instance with decimation 0
    logic        rst_n0, link_v0, tok0, cv0, yumi0, ovf0;
    logic [15:0] link_data0, cdata0;

    bsg_link_sdr_sync_rx #(
        .width_p(16), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(1)
    ) dut (
        .core_clk_i(clk), .core_reset_n_i(rst_n),
        .link_v_i(link_v), .link_data_i(link_data), .link_token_o(tok),
        .core_v_o(cv), .core_data_o(cdata), .core_yumi_i(yumi), .overflow_o(ovf)
    );

    bsg_link_sdr_sync_rx #(
        .width_p(16), .lg_fifo_depth_p(3), .lg_credit_to_token_decimation_p(0)
    ) dut0 (
        .core_clk_i(clk), .core_reset_n_i(rst_n0),
        .link_v_i(link_v0), .link_data_i(link_data0), .link_token_o(tok0),
        .core_v_o(cv0), .core_data_o(cdata0), .core_yumi_i(yumi0), .overflow_o(ovf0)
    );

    int checks = 0;
    int passed = 0;
    int pulses = 0;
    int b2b = 0;
    int illegal_yumi = 0;
    logic tok_prev = 1'b0;
    logic [15:0] expq[$];

    // Token shape and yumi legality, sampled before the edge updates state
    always @(posedge clk) begin
        if (tok && !tok_prev) pulses = pulses + 1;
        if (tok && tok_prev) b2b = b2b + 1;
        tok_prev = tok;
        if (yumi && !cv) illegal_yumi = illegal_yumi + 1;
        if (yumi0 && !cv0) illegal_yumi = illegal_yumi + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst_n = 1'b0; link_v = 1'b0; yumi = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Leaves the last word in the input register (n-1 words already queued)
    task automatic send_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            link_v    = 1'b1;
            link_data = base + 16'(i);
            expq.push_back(base + 16'(i));
            tick(1);
        end
        link_v = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [15:0] e;
        while (expq.size() > 0) begin
            e = expq.pop_front();
            checks++;
            if (cv !== 1'b1) $display("FAIL %s_v: got %b expected 1", name, cv);
            else passed++;
            checks++;
            if (cdata !== e) $display("FAIL %s_data: got %h expected %h", name, cdata, e);
            else passed++;
            yumi = 1'b1;
            tick(1);
        end
        yumi = 1'b0;
        checks++;
        if (cv !== 1'b0) $display("FAIL %s_empty: got %b expected 0", name, cv);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; link_v = 1'b1; link_data = 16'h1234; yumi = 1'b0;
        tick(3);
        checks++;
        if (cv !== 1'b0) $display("FAIL reset_v: got %b expected 0", cv);
        else passed++;
        checks++;
        if (tok !== 1'b0) $display("FAIL reset_token: got %b expected 0", tok);
        else passed++;
        checks++;
        if (ovf !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", ovf);
        else passed++;
        rst_n = 1'b1; link_v = 1'b0;
        tick(2);
        checks++;
        if (cv !== 1'b0) $display("FAIL reset_no_enqueue: got %b expected 0", cv);
        else passed++;
    endtask

    task automatic test_latency;
        int p0;
        do_reset();
        link_v = 1'b1; link_data = 16'hA5A5;
        tick(1);
        link_v = 1'b0;
        checks++;
        if (cv !== 1'b0) $display("FAIL latency_n1: got %b expected 0", cv);
        else passed++;
        tick(1);
        checks++;
        if (cv !== 1'b1) $display("FAIL latency_v: got %b expected 1", cv);
        else passed++;
        checks++;
        if (cdata !== 16'hA5A5) $display("FAIL latency_data: got %h expected a5a5", cdata);
        else passed++;
        p0 = pulses;
        yumi = 1'b1;
        tick(1);
        yumi = 1'b0;
        checks++;
        if (cv !== 1'b0) $display("FAIL latency_deq: got %b expected 0", cv);
        else passed++;
        tick(4);
        checks++;
        if (pulses - p0 !== 0) $display("FAIL latency_no_token: got %0d expected 0", pulses - p0);
        else passed++;
    endtask

    task automatic test_fill_wrap;
        int p0, b0;
        do_reset();
        b0 = b2b;
        for (int r = 0; r < 3; r++) begin
            p0 = pulses;
            send_words(16'(r * 8), 8);
            tick(1);
            drain("wrap");
            tick(4);
            checks++;
            if (pulses - p0 !== 4) $display("FAIL wrap_tokens: got %0d expected 4", pulses - p0);
            else passed++;
        end
        checks++;
        if (b2b - b0 !== 0) $display("FAIL wrap_pulse_width: got %0d expected 0", b2b - b0);
        else passed++;
    endtask

    task automatic test_full_simul;
        do_reset();
        send_words(16'h0010, 8);
        link_v = 1'b1; link_data = 16'h0100;
        expq.push_back(16'h0100);
        tick(1);
        link_v = 1'b0;
        checks++;
        if (cdata !== 16'h0010) $display("FAIL simul_head: got %h expected 0010", cdata);
        else passed++;
        yumi = 1'b1;
        void'(expq.pop_front());
        tick(1);
        yumi = 1'b0;
        checks++;
        if (ovf !== 1'b0) $display("FAIL simul_overflow: got %b expected 0", ovf);
        else passed++;
        drain("simul");
        checks++;
        if (ovf !== 1'b0) $display("FAIL simul_overflow_end: got %b expected 0", ovf);
        else passed++;
    endtask

    task automatic test_overflow;
        do_reset();
        send_words(16'h0020, 8);
        tick(1);
        link_v = 1'b1; link_data = 16'hDEAD;
        tick(1);
        link_v = 1'b0;
        checks++;
        if (ovf !== 1'b0) $display("FAIL ovf_early: got %b expected 0", ovf);
        else passed++;
        tick(1);
        checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", ovf);
        else passed++;
        tick(3);
        checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", ovf);
        else passed++;
        drain("ovf");
        checks++;
        if (ovf !== 1'b1) $display("FAIL ovf_after_drain: got %b expected 1", ovf);
        else passed++;
    endtask

    task automatic test_token_backlog;
        logic exp_tok;
        rst_n0 = 1'b0; link_v0 = 1'b0; yumi0 = 1'b0;
        tick(2);
        rst_n0 = 1'b1;
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < 4; i++) begin
                link_v0 = 1'b1; link_data0 = 16'(16'h0300 + i);
                tick(1);
            end
            link_v0 = 1'b0;
            tick(2);
            for (int c = 0; c < 12; c++) begin
                if (run == 0) exp_tok = (c == 1 || c == 3 || c == 5 || c == 7);
                else          exp_tok = (c == 1 || c == 3);
                checks++;
                if (tok0 !== exp_tok)
                    $display("FAIL backlog_tok run%0d c%0d: got %b expected %b", run, c, tok0, exp_tok);
                else passed++;
                if (c < 4) begin
                    checks++;
                    if (cdata0 !== 16'(16'h0300 + c))
                        $display("FAIL backlog_data c%0d: got %h expected %h", c, cdata0, 16'(16'h0300 + c));
                    else passed++;
                end
                yumi0  = (c < 4) && cv0;
                rst_n0 = !(run == 1 && (c == 4 || c == 5));
                tick(1);
            end
            yumi0 = 1'b0;
        end
    endtask

    task automatic test_yumi_legal;
        checks++;
        if (illegal_yumi !== 0) $display("FAIL yumi_legal: got %0d expected 0", illegal_yumi);
        else passed++;
    endtask

    initial begin
        rst_n = 1'b0; link_v = 1'b0; link_data = '0; yumi = 1'b0;
        rst_n0 = 1'b0; link_v0 = 1'b0; link_data0 = '0; yumi0 = 1'b0;
        test_reset();
        test_latency();
        test_fill_wrap();
        test_full_simul();
        test_overflow();
        test_token_backlog();
        test_yumi_legal();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
